mpu_distributor: RTL and testbench
==================================

Name: mpu_distributor

Overview:
- Reader-side counterpart of the result collector: on a start pulse, reads operand matrices A (M x N) and B (N x N) from the matrix register file into local buffers.
- Then streams them into the FMA cluster as N outer-product beats: column k of A together with row k of B.
- Sits between the matrix register file read port and the FMA cluster operand inputs.

Parameters:
- M, 6, rows of A and of the result.
- N, 6, columns of A; rows and columns of B.
- MBITS, $clog2(M)-1, row index MSB.
- NBITS, $clog2(N)-1, column index MSB.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- start_in  in  1  single-cycle start request
- error_detected_in  in  1  abort request
- busy_out  out  1  high in any state other than DIST_IDLE
- distributor_finished  out  1  single-cycle pulse when the last beat is accepted
- reg_dist_rd_en_out  out  1  register file read enable
- reg_dist_sel_out  out  1  matrix select: 0=A, 1=B
- reg_dist_i_out  out  MBITS+1  read row
- reg_dist_j_out  out  NBITS+1  read column
- reg_dist_element_in  in  32 (float_sp)  read data, valid exactly 1 cycle after rd_en
- feed_valid_out  out  1  beat valid
- cluster_ready_in  in  1  cluster accepts the beat
- feed_k_out  out  NBITS+1  beat index k
- feed_a_col_out  out  M*32  A[0..M-1][k]; A[r][k] sits at bits [32r+31:32r]
- feed_b_row_out  out  N*32  B[k][0..N-1]; B[k][c] sits at bits [32c+31:32c]

Behaviour:
- Clocking and reset: clock clk; reset rst, synchronous, active-high.
- Reset values: state DIST_IDLE; all outputs 0; all counters 0; buffers bufA and bufB 0.
- States: DIST_IDLE, DIST_LOAD_A, DIST_LOAD_B, DIST_DRAIN, DIST_FEED, DIST_DONE.
- DIST_IDLE: start_in=1 -> DIST_LOAD_A next cycle, with i=j=0.
- DIST_LOAD_A: rd_en=1, sel=0, (i,j) walk row-major over M x N, one address per cycle, no gaps.
  - j wraps at N-1 and i increments.
  - After issuing (M-1,N-1) -> DIST_LOAD_B with i=j=0.
- DIST_LOAD_B: same walk with sel=1 over N x N. After issuing (N-1,N-1) -> DIST_DRAIN.
- Read-data capture: a delayed copy of (sel,i,j,rd_en) writes reg_dist_element_in into bufA/bufB at the delayed address. This means the first A element lands while A addresses are still issuing, and the last A element lands during the first LOAD_B cycle.
- DIST_DRAIN: one cycle with rd_en=0; captures the last B element. -> DIST_FEED with k=0.
- Read-port outputs (rd_en, sel, i, j) are registered, so state plus counters drive them with no combinational path from inputs.
- DIST_FEED:
  - feed_valid_out=1; feed_a_col_out/feed_b_row_out/feed_k_out are decoded from the buffers at k.
  - Data is held stable while cluster_ready_in=0; arbitrary stall length is allowed.
  - valid & ready: k increments.
  - valid & ready with k==N-1: -> DIST_DONE.
- DIST_DONE: distributor_finished=1 for exactly one cycle, feed_valid_out=0. -> DIST_IDLE.
- Latency: start_in to first feed_valid_out = 1 + M*N + N*N + 1 cycles (74 for 6x6). Minimum start to finished = that + N.
- start_in while busy: ignored; no restart, no queueing.
- error_detected_in=1 in any non-IDLE state:
  - -> DIST_IDLE next cycle.
  - rd_en and feed_valid_out drop that next cycle; no finished pulse.
  - Buffers are kept but considered stale.
  - error_detected_in takes priority over a simultaneous beat acceptance.
- error_detected_in in DIST_IDLE: no effect. It also blocks start_in in the same cycle.
- rst mid-operation: everything returns to reset values next cycle, including a pending in-flight read, which is discarded.
- Back-to-back: start_in in the cycle after DIST_DONE (state IDLE) is accepted.
- Arithmetic: counters are unsigned; no floating-point operations inside this block.

Decomposition:
- Add distributor_state_e (6 states) to mpu_data_types, alongside collector_state_e.
- float_sp, M, N, MBITS, NBITS come from global_defs/mpu_data_types.
- One natural sub-module: mpu_dist_addr_gen, the row-major (i,j) walker with wrap and last-address flag, parameterised by row and column count. It is instantiated once and reused for the A and B phases via a phase input.

Test Plan:
- Basic load/feed:
  - Stimulus: regfile model with A[r][c]=float(10r+c), B[r][c]=float(100+10r+c), cluster_ready_in tied 1, start pulse.
  - Required: 36 A reads then 36 B reads in row-major order, no gaps. Beat k=2 shows feed_a_col_out row 3 = 32.0 and feed_b_row_out col 4 = 124.0. finished pulses 1 cycle after beat 5; total 80 cycles from start.
- Backpressure:
  - Stimulus: cluster_ready_in low for 5 cycles on beat k=3, then high.
  - Required: k=3 data and valid held unchanged for those 5 cycles; no beat skipped or duplicated; 6 accepted beats total.
- Ignored start:
  - Stimulus: start_in pulsed during LOAD_B and during FEED.
  - Required: no address reset; exactly one finished pulse.
- Abort:
  - Stimulus: error_detected_in at the 20th A read.
  - Required: next cycle busy_out=0, rd_en=0, no finished pulse. A fresh start afterwards completes normally with correct data.
- Reset mid-feed:
  - Stimulus: rst asserted at k=4.
  - Required: all outputs 0 and state IDLE next cycle; buffers zeroed.
- Back-to-back:
  - Stimulus: second start in the first IDLE cycle after finished, with regfile contents changed.
  - Required: second run feeds the new values with identical timing.

Source files
------------

// File: rtl/mpu_distributor_pkg.sv
// mpu_distributor_pkg
// Shared types and dimensions for the MPU operand distributor.
//   float_sp            : raw IEEE-754 single-precision word
//   M, N                : A is M x N, B is N x N
//   MBITS, NBITS        : MSB of row / column indices
//   distributor_state_e : distributor FSM states
`timescale 1ns/1ps
package mpu_distributor_pkg;

  typedef logic [31:0] float_sp;

  localparam int M     = 6;
  localparam int N     = 6;
  localparam int MBITS = $clog2(M) - 1;
  localparam int NBITS = $clog2(N) - 1;

  typedef enum logic [2:0] {
    DIST_IDLE   = 3'd0,
    DIST_LOAD_A = 3'd1,
    DIST_LOAD_B = 3'd2,
    DIST_DRAIN  = 3'd3,
    DIST_FEED   = 3'd4,
    DIST_DONE   = 3'd5
  } distributor_state_e;

  // True in the two states that issue register-file reads.
  function automatic logic is_load_state(input distributor_state_e s);
    return (s == DIST_LOAD_A) || (s == DIST_LOAD_B);
  endfunction

endpackage

// File: rtl/mpu_distributor_if.sv
// mpu_distributor_if
// Control, register-file read port and FMA feed signals of the distributor.
//   master : distributor side (drives *_out, busy, finished)
//   slave  : environment side (drives start, abort, read data, cluster ready)
`timescale 1ns/1ps
interface mpu_distributor_if;
  import mpu_distributor_pkg::*;

  logic               start_in;
  logic               error_detected_in;
  logic               busy_out;
  logic               distributor_finished;
  logic               reg_dist_rd_en_out;
  logic               reg_dist_sel_out;
  logic [MBITS:0]     reg_dist_i_out;
  logic [NBITS:0]     reg_dist_j_out;
  float_sp            reg_dist_element_in;
  logic               feed_valid_out;
  logic               cluster_ready_in;
  logic [NBITS:0]     feed_k_out;
  logic [M*32-1:0]    feed_a_col_out;
  logic [N*32-1:0]    feed_b_row_out;

  modport master (
    input  start_in, error_detected_in, reg_dist_element_in, cluster_ready_in,
    output busy_out, distributor_finished, reg_dist_rd_en_out, reg_dist_sel_out,
           reg_dist_i_out, reg_dist_j_out, feed_valid_out, feed_k_out,
           feed_a_col_out, feed_b_row_out
  );

  modport slave (
    output start_in, error_detected_in, reg_dist_element_in, cluster_ready_in,
    input  busy_out, distributor_finished, reg_dist_rd_en_out, reg_dist_sel_out,
           reg_dist_i_out, reg_dist_j_out, feed_valid_out, feed_k_out,
           feed_a_col_out, feed_b_row_out
  );

endinterface

// File: rtl/mpu_dist_addr_gen.sv
// mpu_dist_addr_gen
// Row-major (i,j) address walker shared by the A and B load phases.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return to (0,0) (has priority over advance)
//   advance  : step to the next address, j wraps at COLS-1 and i increments
//   phase    : 0 = walking A (A_ROWS rows), 1 = walking B (B_ROWS rows)
//   i, j     : current address (registered)
//   last     : current address is the final one of the selected phase
`timescale 1ns/1ps
module mpu_dist_addr_gen #(
  parameter int A_ROWS = 6,
  parameter int B_ROWS = 6,
  parameter int COLS   = 6,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             phase,
  output logic [ROW_W-1:0] i,
  output logic [COL_W-1:0] j,
  output logic             last
);

  logic [ROW_W-1:0] i_r;
  logic [COL_W-1:0] j_r;
  logic [ROW_W-1:0] last_row_s;
  logic             last_s;

  // Final-address detection for the phase currently being walked.
  always_comb begin
    if (phase) begin
      last_row_s = ROW_W'(B_ROWS - 1);
    end else begin
      last_row_s = ROW_W'(A_ROWS - 1);
    end
    last_s = (i_r == last_row_s) && (j_r == COL_W'(COLS - 1));
  end

  // Address counters.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      i_r <= '0;
      j_r <= '0;
    end else if (advance) begin
      if (j_r == COL_W'(COLS - 1)) begin
        j_r <= '0;
        i_r <= i_r + ROW_W'(1);
      end else begin
        j_r <= j_r + COL_W'(1);
      end
    end
  end

  assign i    = i_r;
  assign j    = j_r;
  assign last = last_s;

endmodule

// File: rtl/mpu_distributor.sv
// mpu_distributor
// Loads A (M x N) and B (N x N) from the matrix register file into local
// buffers, then streams N outer-product beats (column k of A, row k of B)
// to the FMA cluster under valid/ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mpu_distributor_if.master (control, regfile read port, feed)
`timescale 1ns/1ps
module mpu_distributor
  import mpu_distributor_pkg::*;
(
  input logic                clk,
  input logic                rst,
  mpu_distributor_if.master  bus
);

  localparam int KW = NBITS + 1;

  distributor_state_e state_r, next_state_s;
  logic [NBITS:0]     k_r, next_k_s;

  logic               ag_clear_s, ag_advance_s, ag_phase_s, ag_last_s;
  logic [MBITS:0]     ag_i_s;
  logic [NBITS:0]     ag_j_s;

  logic               busy_r, rd_en_r, sel_r, valid_r, finished_r;
  logic [M*32-1:0]    a_col_r, a_col_s;
  logic [N*32-1:0]    b_row_r, b_row_s;

  // Delayed copy of the read request, aligned with the returning data.
  logic               cap_en_r, cap_sel_r;
  logic [MBITS:0]     cap_i_r;
  logic [NBITS:0]     cap_j_r;

  float_sp            buf_a_r [M][N];
  float_sp            buf_b_r [N][N];

  mpu_dist_addr_gen #(
    .A_ROWS (M),
    .B_ROWS (N),
    .COLS   (N),
    .ROW_W  (MBITS + 1),
    .COL_W  (NBITS + 1)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (ag_clear_s),
    .advance (ag_advance_s),
    .phase   (ag_phase_s),
    .i       (ag_i_s),
    .j       (ag_j_s),
    .last    (ag_last_s)
  );

  // Next-state, beat index and address-walker control.
  always_comb begin
    next_state_s = state_r;
    next_k_s     = k_r;
    ag_clear_s   = 1'b0;
    ag_advance_s = 1'b0;
    ag_phase_s   = (state_r == DIST_LOAD_B);
    case (state_r)
      DIST_IDLE: begin
        // An abort request in IDLE also masks a simultaneous start.
        if (bus.start_in && !bus.error_detected_in) begin
          next_state_s = DIST_LOAD_A;
          ag_clear_s   = 1'b1;
        end else begin
          next_state_s = DIST_IDLE;
        end
      end
      DIST_LOAD_A: begin
        if (bus.error_detected_in) begin
          next_state_s = DIST_IDLE;
          ag_clear_s   = 1'b1;
        end else if (ag_last_s) begin
          next_state_s = DIST_LOAD_B;
          ag_clear_s   = 1'b1;
        end else begin
          ag_advance_s = 1'b1;
        end
      end
      DIST_LOAD_B: begin
        if (bus.error_detected_in) begin
          next_state_s = DIST_IDLE;
          ag_clear_s   = 1'b1;
        end else if (ag_last_s) begin
          next_state_s = DIST_DRAIN;
          ag_clear_s   = 1'b1;
        end else begin
          ag_advance_s = 1'b1;
        end
      end
      DIST_DRAIN: begin
        if (bus.error_detected_in) begin
          next_state_s = DIST_IDLE;
        end else begin
          next_state_s = DIST_FEED;
          next_k_s     = '0;
        end
      end
      DIST_FEED: begin
        // Abort wins over a beat accepted in the same cycle.
        if (bus.error_detected_in) begin
          next_state_s = DIST_IDLE;
          next_k_s     = '0;
        end else if (valid_r && bus.cluster_ready_in) begin
          if (k_r == KW'(N - 1)) begin
            next_state_s = DIST_DONE;
            next_k_s     = '0;
          end else begin
            next_k_s     = k_r + KW'(1);
          end
        end else begin
          next_k_s = k_r;
        end
      end
      DIST_DONE: begin
        next_state_s = DIST_IDLE;
      end
      default: begin
        next_state_s = DIST_IDLE;
        next_k_s     = '0;
        ag_clear_s   = 1'b1;
      end
    endcase
  end

  // Beat decode from the buffers at the upcoming k. On entry to FEED the
  // last B element is written in the same edge, but it belongs to row N-1,
  // never to row 0, so the k=0 beat is already complete.
  always_comb begin
    a_col_s = '0;
    b_row_s = '0;
    for (int r = 0; r < M; r++) begin
      a_col_s[32*r +: 32] = buf_a_r[r][next_k_s];
    end
    for (int c = 0; c < N; c++) begin
      b_row_s[32*c +: 32] = buf_b_r[next_k_s][c];
    end
  end

  // State, beat index and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DIST_IDLE;
      k_r        <= '0;
      busy_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      sel_r      <= 1'b0;
      valid_r    <= 1'b0;
      finished_r <= 1'b0;
      a_col_r    <= '0;
      b_row_r    <= '0;
    end else begin
      state_r    <= next_state_s;
      k_r        <= next_k_s;
      busy_r     <= (next_state_s != DIST_IDLE);
      rd_en_r    <= is_load_state(next_state_s);
      sel_r      <= (next_state_s == DIST_LOAD_B);
      valid_r    <= (next_state_s == DIST_FEED);
      finished_r <= (next_state_s == DIST_DONE);
      if (next_state_s == DIST_FEED) begin
        a_col_r <= a_col_s;
        b_row_r <= b_row_s;
      end else begin
        a_col_r <= '0;
        b_row_r <= '0;
      end
    end
  end

  // One-cycle delay of the read request to match the regfile latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_en_r  <= 1'b0;
      cap_sel_r <= 1'b0;
      cap_i_r   <= '0;
      cap_j_r   <= '0;
    end else begin
      cap_en_r  <= rd_en_r;
      cap_sel_r <= sel_r;
      cap_i_r   <= ag_i_s;
      cap_j_r   <= ag_j_s;
    end
  end

  // Operand buffers written from the returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_a_r[r][c] <= '0;
        end
      end
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_b_r[r][c] <= '0;
        end
      end
    end else if (cap_en_r) begin
      if (cap_sel_r) begin
        buf_b_r[cap_i_r][cap_j_r] <= bus.reg_dist_element_in;
      end else begin
        buf_a_r[cap_i_r][cap_j_r] <= bus.reg_dist_element_in;
      end
    end
  end

  assign bus.busy_out             = busy_r;
  assign bus.distributor_finished = finished_r;
  assign bus.reg_dist_rd_en_out   = rd_en_r;
  assign bus.reg_dist_sel_out     = sel_r;
  assign bus.reg_dist_i_out       = ag_i_s;
  assign bus.reg_dist_j_out       = ag_j_s;
  assign bus.feed_valid_out       = valid_r;
  assign bus.feed_k_out           = k_r;
  assign bus.feed_a_col_out       = a_col_r;
  assign bus.feed_b_row_out       = b_row_r;

endmodule

// File: tb/tb_mpu_distributor.sv
`timescale 1ns/1ps
module tb_mpu_distributor;
  import mpu_distributor_pkg::*;

  typedef struct {
    int         cyc;
    logic       sel;
    logic [2:0] i;
    logic [2:0] j;
  } rd_t;

  typedef struct {
    int           cyc;
    logic [2:0]   k;
    logic [191:0] a;
    logic [191:0] b;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  float_sp mem_a [M][N];
  float_sp mem_b [N][N];

  rd_t   exp_rd[$];
  beat_t exp_beat[$];
  int    exp_fin[$];

  mpu_distributor_if bus();

  mpu_distributor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: data valid one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.reg_dist_rd_en_out) begin
      if (bus.reg_dist_sel_out)
        bus.reg_dist_element_in <= mem_b[bus.reg_dist_i_out][bus.reg_dist_j_out];
      else
        bus.reg_dist_element_in <= mem_a[bus.reg_dist_i_out][bus.reg_dist_j_out];
    end
  end

  // Small non-negative integer to single-precision bits.
  function automatic logic [31:0] itof(input int v);
    int p;
    logic [31:0] u;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++) if (v[b]) p = b;
    u = v;
    return {1'b0, 8'(127 + p), 23'((u << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [191:0] model_a(input int k);
    logic [191:0] v;
    for (int r = 0; r < M; r++) v[32*r +: 32] = mem_a[r][k];
    return v;
  endfunction

  function automatic logic [191:0] model_b(input int k);
    logic [191:0] v;
    for (int c = 0; c < N; c++) v[32*c +: 32] = mem_b[k][c];
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic fill_mems(input int base_a, input int base_b);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r][c] = itof(base_a + 10*r + c);
        mem_b[r][c] = itof(base_b + 10*r + c);
      end
  endtask

  task automatic push_reads(input int s, input int count);
    rd_t e;
    for (int n = 0; n < count; n++) begin
      e.cyc = s + 1 + n;
      e.sel = (n >= M*N);
      e.i   = (n < M*N) ? 3'(n / N) : 3'((n - M*N) / N);
      e.j   = 3'(n % N);
      exp_rd.push_back(e);
    end
  endtask

  task automatic push_beats(input int s, input int last_k, input int stall_k, input int stall_len);
    beat_t e;
    for (int k = 0; k <= last_k; k++) begin
      e.cyc = s + 74 + k + ((k >= stall_k) ? stall_len : 0);
      e.k   = 3'(k);
      e.a   = model_a(k);
      e.b   = model_b(k);
      exp_beat.push_back(e);
    end
  endtask

  task automatic push_full_run(input int s, input int stall_k, input int stall_len);
    push_reads(s, M*N + N*N);
    push_beats(s, N - 1, stall_k, stall_len);
    exp_fin.push_back(s + 80 + stall_len);
  endtask

  task automatic do_start(output int s);
    s = cyc;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_rd.size() != 0 || exp_beat.size() != 0 || exp_fin.size() != 0 ||
            bus.busy_out) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy or expectations pending after %0d cycles", name, limit);
    end
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},     bus.busy_out, 0);
    chk({tag, "_fin"},      bus.distributor_finished, 0);
    chk({tag, "_rd_en"},    bus.reg_dist_rd_en_out, 0);
    chk({tag, "_sel"},      bus.reg_dist_sel_out, 0);
    chk({tag, "_addr"},     {bus.reg_dist_i_out, bus.reg_dist_j_out}, 0);
    chk({tag, "_valid"},    bus.feed_valid_out, 0);
    chk({tag, "_k"},        bus.feed_k_out, 0);
    chk({tag, "_acol"},     bus.feed_a_col_out, 0);
    chk({tag, "_brow"},     bus.feed_b_row_out, 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents an output event.
  task automatic monitor();
    rd_t   r;
    beat_t b;
    int    f;
    forever begin
      @(negedge clk);
      if (bus.reg_dist_rd_en_out) begin
        if (exp_rd.size() == 0) begin
          chk("rd_unexpected", bus.reg_dist_rd_en_out, 0);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_addr", {bus.reg_dist_sel_out, bus.reg_dist_i_out, bus.reg_dist_j_out},
              {r.sel, r.i, r.j});
          chk("rd_cycle", cyc, r.cyc);
        end
      end
      if (bus.feed_valid_out && bus.cluster_ready_in) begin
        if (exp_beat.size() == 0) begin
          chk("beat_unexpected", bus.feed_valid_out, 0);
        end else begin
          b = exp_beat.pop_front();
          chk("beat_k", bus.feed_k_out, b.k);
          chk("beat_acol", bus.feed_a_col_out, b.a);
          chk("beat_brow", bus.feed_b_row_out, b.b);
          chk("beat_cycle", cyc, b.cyc);
        end
      end
      if (bus.distributor_finished) begin
        if (exp_fin.size() == 0) begin
          chk("fin_unexpected", bus.distributor_finished, 0);
        end else begin
          f = exp_fin.pop_front();
          chk("fin_cycle", cyc, f);
        end
      end
    end
  endtask

  task automatic stimulus();
    int s;
    logic [31:0] acc;

    bus.start_in          = 1'b0;
    bus.error_detected_in = 1'b0;
    bus.cluster_ready_in  = 1'b1;
    fill_mems(0, 100);
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero("reset");
    chk("reset_state", dut.state_r, DIST_IDLE);
    tick();
    rst = 1'b0;
    tick();

    // Abort request in IDLE blocks a simultaneous start.
    bus.start_in = 1'b1;
    bus.error_detected_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    bus.error_detected_in = 1'b0;
    @(negedge clk);
    chk("idle_err_blocks_start", bus.busy_out, 0);
    tick();

    // Basic load/feed with spot values on beat 2.
    s = cyc;
    push_full_run(s, 99, 0);
    do_start(s);
    wait_cyc(s + 76);
    @(negedge clk);
    chk("k2_a_row3", bus.feed_a_col_out[3*32 +: 32], 32'h4200_0000);
    chk("k2_b_col4", bus.feed_b_row_out[4*32 +: 32], 32'h42F8_0000);
    wait_drain("basic", 200);

    // Backpressure: ready low for 5 cycles while beat 3 is presented.
    s = cyc;
    push_full_run(s, 3, 5);
    do_start(s);
    wait_cyc(s + 77);
    bus.cluster_ready_in = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall_valid", bus.feed_valid_out, 1);
      chk("stall_k", bus.feed_k_out, 3);
      chk("stall_acol", bus.feed_a_col_out, model_a(3));
      chk("stall_brow", bus.feed_b_row_out, model_b(3));
      tick();
    end
    bus.cluster_ready_in = 1'b1;
    wait_drain("backpressure", 200);

    // Starts during LOAD_B and FEED are ignored.
    s = cyc;
    push_full_run(s, 99, 0);
    do_start(s);
    wait_cyc(s + 50);
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_cyc(s + 76);
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    wait_drain("ignored_start", 200);

    // Abort on the 20th A read, then a fresh run with new data.
    s = cyc;
    push_reads(s, 20);
    do_start(s);
    wait_cyc(s + 20);
    bus.error_detected_in = 1'b1;
    tick();
    bus.error_detected_in = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy_out, 0);
    chk("abort_rd_en", bus.reg_dist_rd_en_out, 0);
    chk("abort_valid", bus.feed_valid_out, 0);
    wait_drain("abort", 50);
    fill_mems(200, 300);
    s = cyc;
    push_full_run(s, 99, 0);
    do_start(s);
    wait_drain("after_abort", 200);

    // Reset asserted while beat 4 is presented.
    s = cyc;
    push_reads(s, M*N + N*N);
    push_beats(s, 4, 99, 0);
    do_start(s);
    wait_cyc(s + 78);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    chk("midrst_state", dut.state_r, DIST_IDLE);
    acc = 32'h0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) acc = acc | dut.buf_a_r[r][c] | dut.buf_b_r[r][c];
    chk("midrst_bufs", acc, 0);
    wait_drain("midrst", 50);

    // Back-to-back: second start in the first IDLE cycle after finished.
    fill_mems(0, 100);
    s = cyc;
    push_full_run(s, 99, 0);
    do_start(s);
    wait_cyc(s + 78);
    fill_mems(500, 600);
    wait_cyc(s + 81);
    push_full_run(s + 81, 99, 0);
    do_start(s);
    wait_drain("back_to_back", 250);

    chk("left_reads", exp_rd.size(), 0);
    chk("left_beats", exp_beat.size(), 0);
    chk("left_fin", exp_fin.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
